fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage for the MIPS core.
- Holds the PC and requests instruction words from instruction memory over a req/valid handshake.
- Latches each returned word in an instruction register and drives opcode/funct to the control decoder.
- Consumes the decoder's Jump/Branch/NEqual/Jr outputs, plus ALU zero and rs data, to select the next PC when the core commits.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned).
- IMEM_AW, 30, instruction-memory word-address width; imem_addr = pc[IMEM_AW+1:2].

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, held high in S_FETCH.
- imem_addr  out  IMEM_AW  word address, equal to pc[IMEM_AW+1:2].
- imem_rdata  in  32  instruction word, valid when imem_valid=1.
- imem_valid  in  1  read data valid; sampled only in S_FETCH.
- instr  out  32  instruction register.
- instr_valid  out  1  high in S_EXEC.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- pc  out  32  PC of the instruction in instr.
- pc_plus4  out  32  pc+4; doubles as the jal link value.
- jump, branch, nequal, jr  in  1 each  from the control decoder.
- zero  in  1  ALU zero flag.
- rs_data  in  32  register rs value, used as the jr target.
- commit  in  1  core has finished the current instruction; sampled only in S_EXEC.

Behaviour:
- Reset (rst=1 at an edge, wins over all other inputs, including mid-fetch or mid-exec):
  - pc=RESET_PC, instr=0, state=S_FETCH.
  - instr_valid=0, imem_req=0 in the cycle after reset; imem_req rises in the following cycle.
  - An internal req_armed flag delays the first request by one cycle.
- States:
  - S_FETCH: imem_req=1. If imem_valid=1 at an edge, instr<=imem_rdata and go to S_EXEC. Otherwise stay; no timeout.
  - S_EXEC: instr_valid=1, imem_req=0. If commit=1 at an edge, pc<=next_pc and go to S_FETCH. Otherwise hold instr and pc.
- Minimum throughput: 2 cycles per instruction (valid in the same cycle as req, commit in the first S_EXEC cycle).
- next_pc priority:
  - jr=1: {rs_data[31:2],2'b00}; low two bits are silently cleared.
  - else jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch=1 and (zero XOR nequal)=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - else: pc_plus4.
- jal uses the jump path; link data is pc_plus4, and the register-file write is outside this block.
- All adds are 32-bit modulo: pc=32'hFFFF_FFFC gives pc_plus4=0, and branch targets wrap likewise.
- imem_valid outside S_FETCH and commit outside S_EXEC are ignored.
- opcode, funct, pc, pc_plus4 are combinational from registered state; they are stable throughout S_EXEC.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two extra outputs:
  - retired_cnt [31:0]: increments on every S_EXEC commit.
  - redirect_cnt [31:0]: increments on commits where next_pc != pc_plus4.
  - Both clear on rst and wrap at 2^32.
- When undefined, these ports and counters do not exist.
- Core behaviour is identical either way.

Test Plan:
- Reset then sequential fetch: RESET_PC=0, imem_valid same cycle, commit immediately, 3 non-branch instructions -> imem_addr 0,1,2; pc 0,4,8; each instr_valid pulse is 1 cycle.
- Memory wait: imem_valid delayed 3 cycles at pc=0x10 -> imem_req held 4 cycles, instr unchanged until valid, instr_valid then high.
- beq taken/not taken: instr imm=16'hFFFE at pc=0x20, branch=1, nequal=0:
  - zero=1 -> next pc=0x1C.
  - zero=0 -> next pc=0x24.
  - Same instruction with nequal=1 inverts both results.
- Jump and jr priority: pc=0x4000_0000, instr[25:0]=26'h10, jump=1 -> next pc 0x4000_0040. Same cycle with jr=1, rs_data=0x123 -> next pc 0x120.
- Wrap and stall: pc=0xFFFF_FFFC, commit=0 for 5 cycles -> pc/instr held. Then commit -> pc=0, pc_plus4=4.
- Reset mid-fetch and counters: assert rst in S_FETCH with a later imem_valid -> pc=RESET_PC, imem_req=0 in the cycle after reset. With FETCH_PERF_CNT_EN, 4 commits including 1 taken branch -> retired_cnt=4, redirect_cnt=1.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC-sequencing stage: fetches one word per instruction over a
// req/valid handshake and picks the next PC on commit. Optional: FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 30
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_valid,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               jump,
  input  logic               branch,
  input  logic               nequal,
  input  logic               jr,
  input  logic               zero,
  input  logic [31:0]        rs_data,
  input  logic               commit
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        retired_cnt,
  output logic [31:0]        redirect_cnt
`endif
);

  typedef enum logic {S_FETCH, S_EXEC} state_t;

  state_t      state, state_nxt;
  logic        req_armed;
  logic [31:0] pc_p0;
  logic [31:0] instr_p0;
  logic [31:0] next_pc;
  logic        take_fetch;
  logic        take_commit;
  logic        unused_rs_lsb;

  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] seq_pc,
                                              input logic [25:0] idx);
    return {seq_pc[31:28], idx, 2'b00};
  endfunction

  assign unused_rs_lsb = ^rs_data[1:0];

  assign pc        = pc_p0;
  assign instr     = instr_p0;
  assign pc_plus4  = pc_p0 + 32'd4;
  assign imem_addr = pc_p0[IMEM_AW+1:2];
  assign opcode    = instr_p0[31:26];
  assign funct     = instr_p0[5:0];

  always_comb begin
    next_pc = pc_plus4;
    if (jr)
      next_pc = {rs_data[31:2], 2'b00};
    else if (jump)
      next_pc = jump_target(pc_plus4, instr_p0[25:0]);
    else if (branch && (zero ^ nequal))
      next_pc = pc_plus4 + $unsigned(branch_offset(instr_p0[15:0]));
  end

  always_comb begin
    state_nxt   = state;
    take_fetch  = 1'b0;
    take_commit = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_FETCH: begin
        // First request after reset is held off one cycle by req_armed.
        imem_req = req_armed;
        if (imem_valid) begin
          take_fetch = 1'b1;
          state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (commit) begin
          take_commit = 1'b1;
          state_nxt   = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // ---- state / instruction register / PC ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      req_armed <= 1'b0;
      pc_p0     <= RESET_PC;
      instr_p0  <= 32'd0;
    end else begin
      state     <= state_nxt;
      req_armed <= 1'b1;
      if (take_fetch)
        instr_p0 <= imem_rdata;
      if (take_commit)
        pc_p0 <= next_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // ---- performance counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt  <= 32'd0;
      redirect_cnt <= 32'd0;
    end else if (take_commit) begin
      retired_cnt <= retired_cnt + 32'd1;
      if (next_pc != pc_plus4)
        redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reference model of PC/instr/handshake state
// is checked every cycle, and every committed instruction pins a literal next PC.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        jump, branch, nequal, jr, zero;
  logic [31:0] rs_data;
  logic        commit;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] redirect_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(30)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr(instr), .instr_valid(instr_valid),
    .opcode(opcode), .funct(funct),
    .pc(pc), .pc_plus4(pc_plus4),
    .jump(jump), .branch(branch), .nequal(nequal), .jr(jr), .zero(zero),
    .rs_data(rs_data), .commit(commit)
`ifdef FETCH_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .redirect_cnt(redirect_cnt)
`endif
  );

  localparam logic [31:0] NOP  = 32'h0000_0020;
  localparam logic [31:0] J8   = 32'h0800_0008;
  localparam logic [31:0] J10  = 32'h0800_0010;
  localparam logic [31:0] BEQ  = 32'h1000_FFFE;
  localparam logic [31:0] JRI  = 32'h0000_0008;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // reference model state, updated just after each active edge
  logic [31:0] m_pc, m_instr, m_ret, m_redir;
  logic        m_req, m_ivld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic j_r, input logic j, input logic b,
                                             input logic ne, input logic z,
                                             input logic [31:0] rs);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (j_r) return rs & 32'hFFFF_FFFC;
    if (j)   return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (b && (z != ne)) begin
      off = $signed(ins[15:0]) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req",    32'(imem_req),    32'(m_req));
      chk("instr_valid", 32'(instr_valid), 32'(m_ivld));
      chk("pc",          pc,               m_pc);
      chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
      chk("imem_addr",   32'(imem_addr),   m_pc >> 2);
      chk("instr",       instr,            m_instr);
      chk("opcode",      32'(opcode),      32'(m_instr[31:26]));
      chk("funct",       32'(funct),       32'(m_instr[5:0]));
`ifdef FETCH_PERF_CNT_EN
      chk("retired_cnt",  retired_cnt,  m_ret);
      chk("redirect_cnt", redirect_cnt, m_redir);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // reset asserted with a pending valid and commit: reset must win over both
  task automatic do_reset();
    rst = 1'b1; imem_valid = 1'b1; commit = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    cyc();
    rst = 1'b0; imem_valid = 1'b0; commit = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_req = 1'b0; m_ivld = 1'b0;
    m_ret = 32'h0; m_redir = 32'h0;
    chk_en = 1'b1;
    chk("rst_pc",  pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    cyc();
    m_req = 1'b1;
    chk("armed_req", 32'(imem_req), 32'h1);
  endtask

  task automatic fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0; imem_rdata = $urandom; commit = 1'b1;
      cyc();
    end
    imem_valid = 1'b1; imem_rdata = word; commit = 1'b0;
    cyc();
    imem_valid = 1'b0;
    m_instr = word; m_req = 1'b0; m_ivld = 1'b1;
  endtask

  task automatic exec(input logic j_r, input logic j, input logic b, input logic ne,
                      input logic z, input logic [31:0] rs, input int stall);
    logic [31:0] nxt;
    jr = j_r; jump = j; branch = b; nequal = ne; zero = z; rs_data = rs;
    for (int i = 0; i < stall; i++) begin
      commit = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      cyc();
    end
    commit = 1'b1; imem_valid = 1'b0;
    nxt = model_next(m_pc, m_instr, j_r, j, b, ne, z, rs);
    cyc();
    commit = 1'b0;
    jr = 1'b0; jump = 1'b0; branch = 1'b0; nequal = 1'b0; zero = 1'b0;
    m_ret = m_ret + 32'd1;
    if (nxt != m_pc + 32'd4) m_redir = m_redir + 32'd1;
    m_pc = nxt; m_ivld = 1'b0; m_req = 1'b1;
  endtask

  task automatic step(input logic [31:0] word, input int waits,
                      input logic j_r, input logic j, input logic b, input logic ne,
                      input logic z, input logic [31:0] rs, input int stall,
                      input logic [31:0] exp_pc);
    fetch(word, waits);
    exec(j_r, j, b, ne, z, rs, stall);
    chk("next_pc", pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_valid = 1'b0; imem_rdata = 32'h0; commit = 1'b0;
    jump = 1'b0; branch = 1'b0; nequal = 1'b0; jr = 1'b0; zero = 1'b0; rs_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // sequential fetch, then a 3-cycle memory wait at 0x10
    step(NOP, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0004);
    step(NOP, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0008);
    step(NOP, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0000_000C);
    step(NOP, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0010);
    step(NOP, 3, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0014);
    step(J8,  0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0000_0020);

    // beq / bne at 0x20 with imm -2
    step(BEQ, 0, 0, 0, 1, 0, 1, 32'h0, 0, 32'h0000_001C);
    step(NOP, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0020);
    step(BEQ, 0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0000_0024);
    step(J8,  0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0000_0020);
    step(BEQ, 0, 0, 0, 1, 1, 1, 32'h0, 0, 32'h0000_0024);
    step(J8,  0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0000_0020);
    step(BEQ, 0, 0, 0, 1, 1, 0, 32'h0, 1, 32'h0000_001C);

    // jr with low bits set, jump region, jr over jump priority
    step(JRI, 0, 1, 0, 0, 0, 0, 32'h4000_0003, 0, 32'h4000_0000);
    step(J10, 0, 0, 1, 0, 0, 0, 32'h0,         0, 32'h4000_0040);
    step(JRI, 0, 1, 0, 0, 0, 0, 32'h4000_0000, 0, 32'h4000_0000);
    step(J10, 0, 1, 1, 0, 0, 0, 32'h0000_0123, 0, 32'h0000_0120);

    // wrap at top of address space, with a 5-cycle stall
    step(JRI, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
    step(NOP, 1, 0, 0, 0, 0, 0, 32'h0, 5, 32'h0000_0000);
    chk("wrap_pc_plus4", pc_plus4, 32'h0000_0004);
    step(BEQ, 0, 0, 0, 1, 0, 1, 32'h0, 0, 32'hFFFF_FFFC);
    step(NOP, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0000);

    // reset in the middle of a fetch, then four commits with one taken branch
    imem_valid = 1'b0;
    cyc();
    do_reset();
    step(NOP, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0004);
    step(NOP, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0008);
    step(BEQ, 0, 0, 0, 1, 0, 1, 32'h0, 0, 32'h0000_0004);
    step(NOP, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0008);
`ifdef FETCH_PERF_CNT_EN
    chk("retired_lit",  retired_cnt,  32'd4);
    chk("redirect_lit", redirect_cnt, 32'd1);
`endif

    // reset while waiting in S_EXEC
    fetch(NOP, 0);
    cyc();
    do_reset();
    chk("exec_rst_instr", instr, 32'h0);
    step(NOP, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0004);

    cyc();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
